// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver: one digit per slot, blank dead-time, per-frame input shadowing.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] nums_enable,
  output logic [6:0] display,
  output logic [3:0] selector,
  output logic       frame_tick
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW:0]    BLANK_W  = (CW + 1)'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} phase_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   nums_q, nums_d;
  logic [3:0]    en_q, en_d;
  logic          run_q, run_d;
  phase_e        state_q, state_d;
  logic [6:0]    display_q, display_d;
  logic [3:0]    selector_q, selector_d;
  logic          tick_q, tick_d;
  logic [3:0]    lz_s, en_eff_s, digit_s;
  logic          on_s;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      4'hF: hex_decode = 7'b0001110;
      default: hex_decode = 7'b1111111;
    endcase
  endfunction

  // The edge that leaves reset (run_q low) holds position 0 so the first free-running cycle is cnt=0, idx=0.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    nums_d = nums_q;
    en_d   = en_q;
    run_d  = 1'b1;
    if (rst) begin
      cnt_d  = '0;
      idx_d  = 2'd0;
      nums_d = {num3, num2, num1, num0};
      en_d   = nums_enable;
      run_d  = 1'b0;
    end else if (!run_q) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        nums_d = {num3, num2, num1, num0};
        en_d   = nums_enable;
      end else begin
        nums_d = nums_q;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: state_d = ({1'b0, cnt_d} >= BLANK_W) ? ST_DRIVE : ST_BLANK;
        ST_DRIVE: state_d = ({1'b0, cnt_d} <  BLANK_W) ? ST_BLANK : ST_DRIVE;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

  // Outputs are decoded from next-state values so they line up with cnt/idx without a cycle of lag.
  always_comb begin
    lz_s    = 4'b0000;
`ifdef SEG7_LZB_EN
    lz_s[3] = (nums_d[15:12] == 4'h0);
    lz_s[2] = lz_s[3] && (nums_d[11:8] == 4'h0);
    lz_s[1] = lz_s[2] && (nums_d[7:4] == 4'h0);
    lz_s[0] = 1'b0;
`else
    lz_s    = 4'b0000;
`endif
    en_eff_s   = en_d & ~lz_s;
    digit_s    = nums_d[{idx_d, 2'b00} +: 4];
    on_s       = !rst && (state_d == ST_DRIVE) && en_eff_s[idx_d];
    selector_d = on_s ? ~(4'b0001 << idx_d) : 4'b1111;
    display_d  = on_s ? hex_decode(digit_s) : 7'b1111111;
    tick_d     = !rst && (idx_d == 2'd3) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      run_q      <= 1'b0;
      state_q    <= ST_BLANK;
      nums_q     <= nums_d;
      en_q       <= en_d;
      display_q  <= 7'b1111111;
      selector_q <= 4'b1111;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      state_q    <= state_d;
      nums_q     <= nums_d;
      en_q       <= en_d;
      display_q  <= display_d;
      selector_q <= selector_d;
      tick_q     <= tick_d;
    end
  end

  assign display    = display_q;
  assign selector   = selector_q;
  assign frame_tick = tick_q;

endmodule
